// File: rtl/vm2002_change_dispenser_if.sv
// Signal bundle between the vm2002 coin controller (master) and the change dispenser (slave).
// Handshake: a change request transfers on a rising clk edge where chg_valid && chg_ready; load_valid is a one-cycle strobe.
interface vm2002_change_dispenser_if #(
    parameter int COIN_CNT_W = 6
);
    logic                  chg_valid;
    logic [15:0]           chg_amount;
    logic                  chg_ready;
    logic                  load_valid;
    logic [1:0]            load_coin;
    logic [3:0]            load_qty;
    logic [1:0]            coin_out;
    logic                  coin_strobe;
    logic                  busy;
    logic                  done;
    logic                  short;
    logic [15:0]           short_amt;
    logic [COIN_CNT_W-1:0] nickel_cnt;
    logic [COIN_CNT_W-1:0] dime_cnt;
    logic [COIN_CNT_W-1:0] quarter_cnt;

    modport master (
        output chg_valid, chg_amount, load_valid, load_coin, load_qty,
        input  chg_ready, coin_out, coin_strobe, busy, done, short, short_amt,
               nickel_cnt, dime_cnt, quarter_cnt
    );

    modport slave (
        input  chg_valid, chg_amount, load_valid, load_coin, load_qty,
        output chg_ready, coin_out, coin_strobe, busy, done, short, short_amt,
               nickel_cnt, dime_cnt, quarter_cnt
    );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Pays a change amount back greedily (quarter, dime, nickel) from an internal coin inventory,
// one coin strobe at a time, and reports whatever could not be paid.
module vm2002_change_dispenser #(
    parameter int COIN_CNT_W = 6,
    parameter int PULSE_GAP  = 2
) (
    input  logic                     clk,
    input  logic                     hrst_n,
    vm2002_change_dispenser_if.slave bus,
    output logic [2:0]               dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_EMIT   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] C_NONE    = 2'b00;
    localparam logic [1:0] C_NICKEL  = 2'b01;
    localparam logic [1:0] C_DIME    = 2'b10;
    localparam logic [1:0] C_QUARTER = 2'b11;
    localparam logic [COIN_CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [7:0]            GAP_LAST = (PULSE_GAP > 0) ? 8'(PULSE_GAP - 1) : 8'd0;

    state_e                state_q, state_d;
    logic [15:0]           rem_q, rem_d;
    logic [1:0]            coin_q, coin_d;
    logic [7:0]            gap_q, gap_d;
    logic [COIN_CNT_W-1:0] nick_q, nick_d, dime_q, dime_d, quar_q, quar_d;
    logic                  short_q, short_d;
    logic [15:0]           short_amt_q, short_amt_d;

    function automatic logic [COIN_CNT_W-1:0] sat_add(input logic [COIN_CNT_W-1:0] cnt,
                                                      input logic [3:0] qty);
        logic [COIN_CNT_W+4:0] sum;
        sum = {5'd0, cnt} + {{(COIN_CNT_W+1){1'b0}}, qty};
        return (sum > {5'd0, CNT_MAX}) ? CNT_MAX : sum[COIN_CNT_W-1:0];
    endfunction

    function automatic logic [15:0] coin_value(input logic [1:0] coin);
        case (coin)
            C_QUARTER: return 16'd25;
            C_DIME:    return 16'd10;
            C_NICKEL:  return 16'd5;
            default:   return 16'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            coin_q      <= C_NONE;
            gap_q       <= '0;
            nick_q      <= '0;
            dime_q      <= '0;
            quar_q      <= '0;
            short_q     <= 1'b0;
            short_amt_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            coin_q      <= coin_d;
            gap_q       <= gap_d;
            nick_q      <= nick_d;
            dime_q      <= dime_d;
            quar_q      <= quar_d;
            short_q     <= short_d;
            short_amt_q <= short_amt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        coin_d      = coin_q;
        gap_d       = gap_q;
        nick_d      = nick_q;
        dime_d      = dime_q;
        quar_d      = quar_q;
        short_d     = short_q;
        short_amt_d = short_amt_q;
        case (state_q)
            S_IDLE: begin
                // A refill and an accept in the same cycle both land; SELECT sees the new count.
                if (bus.load_valid) begin
                    case (bus.load_coin)
                        C_NICKEL:  nick_d = sat_add(nick_q, bus.load_qty);
                        C_DIME:    dime_d = sat_add(dime_q, bus.load_qty);
                        C_QUARTER: quar_d = sat_add(quar_q, bus.load_qty);
                        default:   ;
                    endcase
                end
                if (bus.chg_valid) begin
                    rem_d       = bus.chg_amount;
                    short_d     = 1'b0;
                    short_amt_d = '0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (rem_q >= 16'd25 && quar_q != '0) begin
                    coin_d  = C_QUARTER;
                    state_d = S_EMIT;
                end else if (rem_q >= 16'd10 && dime_q != '0) begin
                    coin_d  = C_DIME;
                    state_d = S_EMIT;
                end else if (rem_q >= 16'd5 && nick_q != '0) begin
                    coin_d  = C_NICKEL;
                    state_d = S_EMIT;
                end else begin
                    // Remainder is final here, so publish it so it is valid alongside done.
                    short_d     = (rem_q != 16'd0);
                    short_amt_d = rem_q;
                    state_d     = S_DONE;
                end
            end
            S_EMIT: begin
                rem_d = rem_q - coin_value(coin_q);
                case (coin_q)
                    C_NICKEL:  nick_d = nick_q - 1'b1;
                    C_DIME:    dime_d = dime_q - 1'b1;
                    C_QUARTER: quar_d = quar_q - 1'b1;
                    default:   ;
                endcase
                gap_d   = '0;
                state_d = (PULSE_GAP > 0) ? S_GAP : S_SELECT;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_SELECT;
                else                   gap_d   = gap_q + 8'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.chg_ready   = (state_q == S_IDLE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.coin_strobe = (state_q == S_EMIT);
    assign bus.coin_out    = (state_q == S_EMIT) ? coin_q : C_NONE;
    assign bus.done        = (state_q == S_DONE);
    assign bus.short       = short_q;
    assign bus.short_amt   = short_amt_q;
    assign bus.nickel_cnt  = nick_q;
    assign bus.dime_cnt    = dime_q;
    assign bus.quarter_cnt = quar_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Bench for vm2002_change_dispenser: directed scenarios plus randomized requests against a
// closed-form greedy payout model of the inventory.
module tb_vm2002_change_dispenser;
  localparam int W    = 6;
  localparam int GAP  = 2;
  localparam int MAXC = 63;
  localparam int PER  = 2 + GAP;

  logic       clk = 1'b0;
  logic       hrst_n;
  logic [2:0] dbg_state;

  vm2002_change_dispenser_if #(.COIN_CNT_W(W)) bus ();

  vm2002_change_dispenser #(.COIN_CNT_W(W), .PULSE_GAP(GAP)) dut (
    .clk         (clk),
    .hrst_n      (hrst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mq, md, mn;
  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [1:0] obs_q[$];
  int         obs_cyc_q[$];

  // ---------------- clock/reset and drivers ----------------
  task automatic drive_idle();
    bus.chg_valid  = 1'b0;
    bus.chg_amount = '0;
    bus.load_valid = 1'b0;
    bus.load_coin  = 2'b00;
    bus.load_qty   = 4'd0;
  endtask

  task automatic apply_reset();
    drive_idle();
    hrst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    hrst_n = 1'b1;
    mq = 0; md = 0; mn = 0;
  endtask

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic void model_load(input logic [1:0] c, input int q);
    if (c == 2'b01) mn = sat(mn + q);
    if (c == 2'b10) md = sat(md + q);
    if (c == 2'b11) mq = sat(mq + q);
  endfunction

  task automatic do_load(input logic [1:0] c, input int q);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.load_coin  = c;
    bus.load_qty   = 4'(q);
    @(negedge clk);
    bus.load_valid = 1'b0;
    model_load(c, q);
  endtask

  task automatic check_counts(input string tag);
    checks++;
    if (bus.quarter_cnt !== W'(mq)) begin
      errors++;
      $display("FAIL %s quarter_cnt: got %0d expected %0d", tag, bus.quarter_cnt, mq);
    end
    checks++;
    if (bus.dime_cnt !== W'(md)) begin
      errors++;
      $display("FAIL %s dime_cnt: got %0d expected %0d", tag, bus.dime_cnt, md);
    end
    checks++;
    if (bus.nickel_cnt !== W'(mn)) begin
      errors++;
      $display("FAIL %s nickel_cnt: got %0d expected %0d", tag, bus.nickel_cnt, mn);
    end
  endtask

  // One full request: optional same-cycle refill, optional refill attempt while busy.
  task automatic run_request(input string tag, input int amt, input bit with_load,
                             input logic [1:0] lc, input int lq, input bit busy_load);
    int r, nq, nd, nn, n, cyc, done_cyc;
    bit got_done;
    logic       o_short;
    logic [15:0] o_amt;
    exp_q.delete(); exp_cyc_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    @(negedge clk);
    bus.chg_valid  = 1'b1;
    bus.chg_amount = 16'(amt);
    if (with_load) begin
      bus.load_valid = 1'b1;
      bus.load_coin  = lc;
      bus.load_qty   = 4'(lq);
      model_load(lc, lq);
    end
    r  = amt;
    nq = (r / 25 < mq) ? r / 25 : mq; r -= 25 * nq; mq -= nq;
    nd = (r / 10 < md) ? r / 10 : md; r -= 10 * nd; md -= nd;
    nn = (r / 5 < mn) ? r / 5 : mn;   r -= 5 * nn;  mn -= nn;
    for (int i = 0; i < nq; i++) exp_q.push_back(2'b11);
    for (int i = 0; i < nd; i++) exp_q.push_back(2'b10);
    for (int i = 0; i < nn; i++) exp_q.push_back(2'b01);
    n = exp_q.size();
    for (int i = 0; i < n; i++) exp_cyc_q.push_back(2 + i * PER);
    @(posedge clk);
    #1;
    bus.chg_valid  = 1'b0;
    bus.chg_amount = 16'($urandom);
    bus.load_valid = 1'b0;
    cyc = 0; got_done = 1'b0; done_cyc = 0; o_short = 1'b0; o_amt = '0;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.chg_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy/ready in cycle 1: got %b/%b expected 1/0", tag, bus.busy, bus.chg_ready);
        end
      end
      if (bus.coin_strobe === 1'b1) begin
        obs_q.push_back(bus.coin_out);
        obs_cyc_q.push_back(cyc);
      end
      if (bus.done === 1'b1) begin
        got_done = 1'b1; done_cyc = cyc; o_short = bus.short; o_amt = bus.short_amt;
      end
      if (busy_load && cyc == 3) begin
        bus.load_valid = 1'b1; bus.load_coin = 2'b11; bus.load_qty = 4'd7;
      end
      if (busy_load && cyc == 4) bus.load_valid = 1'b0;
    end
    bus.load_valid = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s done timeout: got none expected done in cycle %0d", tag, 2 + n * PER);
      return;
    end
    checks++;
    if (obs_q.size() != n) begin
      errors++;
      $display("FAIL %s strobe count: got %0d expected %0d", tag, obs_q.size(), n);
    end
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] != exp_cyc_q[i]) begin
        errors++;
        $display("FAIL %s coin %0d: got %b@%0d expected %b@%0d", tag, i, obs_q[i], obs_cyc_q[i],
                 exp_q[i], exp_cyc_q[i]);
      end
    end
    checks++;
    if (done_cyc != 2 + n * PER) begin
      errors++;
      $display("FAIL %s done cycle: got %0d expected %0d", tag, done_cyc, 2 + n * PER);
    end
    checks++;
    if (o_short !== (r != 0) || o_amt !== 16'(r)) begin
      errors++;
      $display("FAIL %s short with done: got %b/%0d expected %b/%0d", tag, o_short, o_amt, r != 0, r);
    end
    @(negedge clk);
    checks++;
    if (bus.chg_ready !== 1'b1 || bus.short !== (r != 0) || bus.short_amt !== 16'(r)) begin
      errors++;
      $display("FAIL %s after done ready/short/amt: got %b/%b/%0d expected 1/%b/%0d", tag,
               bus.chg_ready, bus.short, bus.short_amt, r != 0, r);
    end
    check_counts(tag);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    hrst_n = 1'b0;
    #3;
    checks++;
    if (bus.chg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.coin_strobe !== 1'b0 || bus.coin_out !== 2'b00) begin
      errors++;
      $display("FAIL reset ctrl: got ready=%b busy=%b done=%b strobe=%b coin=%b expected 1/0/0/0/00",
               bus.chg_ready, bus.busy, bus.done, bus.coin_strobe, bus.coin_out);
    end
    checks++;
    if (bus.short !== 1'b0 || bus.short_amt !== 16'd0) begin
      errors++;
      $display("FAIL reset short: got %b/%0d expected 0/0", bus.short, bus.short_amt);
    end
    apply_reset();
    check_counts("reset");
  endtask

  task automatic test_basic();
    do_load(2'b11, 4); do_load(2'b10, 4); do_load(2'b01, 4);
    run_request("basic65", 65, 0, 2'b00, 0, 0);
  endtask

  task automatic test_zero();
    run_request("zero", 0, 0, 2'b00, 0, 0);
  endtask

  task automatic test_short_inventory();
    apply_reset();
    do_load(2'b11, 1); do_load(2'b10, 3);
    run_request("short30", 30, 0, 2'b00, 0, 0);
  endtask

  task automatic test_not_multiple();
    do_load(2'b10, 5); do_load(2'b01, 5);
    run_request("odd17", 17, 0, 2'b00, 0, 0);
  endtask

  task automatic test_refill();
    apply_reset();
    for (int i = 0; i < 5; i++) do_load(2'b11, 15);
    checks++;
    if (bus.quarter_cnt !== 6'd63) begin
      errors++;
      $display("FAIL saturate quarter_cnt: got %0d expected 63", bus.quarter_cnt);
    end
    do_load(2'b00, 9);
    check_counts("load00");
    run_request("busy_load", 30, 0, 2'b00, 0, 1);
    run_request("same_cycle", 10, 1, 2'b01, 2, 0);
  endtask

  task automatic test_reset_mid();
    int strobes, wait_cyc;
    apply_reset();
    do_load(2'b11, 4); do_load(2'b10, 4); do_load(2'b01, 4);
    @(negedge clk);
    bus.chg_valid = 1'b1; bus.chg_amount = 16'd65;
    @(posedge clk);
    #1 bus.chg_valid = 1'b0;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (bus.coin_strobe !== 1'b1 && wait_cyc < 20);
    checks++;
    if (bus.coin_strobe !== 1'b1) begin
      errors++;
      $display("FAIL midreset first strobe: got none expected strobe");
    end
    #2 hrst_n = 1'b0;
    #1;
    mq = 0; md = 0; mn = 0;
    checks++;
    if (bus.coin_strobe !== 1'b0 || bus.coin_out !== 2'b00 || bus.busy !== 1'b0 ||
        bus.chg_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset outputs: got strobe=%b coin=%b busy=%b ready=%b done=%b expected 0/00/0/1/0",
               bus.coin_strobe, bus.coin_out, bus.busy, bus.chg_ready, bus.done);
    end
    check_counts("midreset");
    @(negedge clk);
    hrst_n = 1'b1;
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.coin_strobe !== 1'b0 || bus.chg_ready !== 1'b1) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++;
      $display("FAIL midreset after release: got %0d bad cycles expected 0", strobes);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_load(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0)
        run_request("rand_same", int'($urandom_range(0, 180)), 1, 2'($urandom_range(1, 3)),
                    int'($urandom_range(0, 15)), 0);
      else
        run_request("rand", int'($urandom_range(0, 180)), 0, 2'b00, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_short_inventory();
    test_not_multiple();
    test_refill();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
